// File: rtl/irrigation_pkg.sv
// Shared types and default sizing for the irrigation sequencer slice.
// The state encoding is fixed at 2 bits so downstream observers can decode it.
package irrigation_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ASP   = 2'd1,
    GOT   = 2'd2,
    ALARM = 2'd3
  } state_t;

  localparam int DEF_CNT_W     = 8;
  localparam int DEF_ASP_TICKS = 4;
  localparam int DEF_GOT_TICKS = 8;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous level, plus a one-cycle pulse
// on each synchronized rising edge.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_in,
  output logic q_sync,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: non-blocking assignments make every stage capture the pre-edge value,
  // so the chain really shifts by one flop per clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_sync     = sync_q[SYNC_STAGES-1];
  assign rise_pulse = q_sync & ~prev_q;

endmodule

// File: rtl/irrigation_sequencer.sv
// Irrigation controller: turns the divided sprinkler/drip clocks into ticks and
// runs a valve for a programmed tick count while the soil reads dry.
module irrigation_sequencer
  import irrigation_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ASP_TICKS   = DEF_ASP_TICKS,
  parameter int GOT_TICKS   = DEF_GOT_TICKS,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clock_asp_in,
  input  logic             clock_got_in,
  input  logic             soil_dry,
  input  logic             tank_low,
  input  logic             mode,
  output logic             valve_asp,
  output logic             valve_got,
  output logic             alarm,
  output logic             busy,
  output logic [CNT_W-1:0] ticks_left
);

  localparam logic [CNT_W-1:0] ASP_LOAD = CNT_W'(ASP_TICKS);
  localparam logic [CNT_W-1:0] GOT_LOAD = CNT_W'(GOT_TICKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic tick_asp, tick_got;
  logic asp_level, got_level;
  logic soil_dry_s, tank_low_s, mode_s;
  logic [2:0] sensor_rise;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_asp (
    .clock(clock), .reset(reset), .d_in(clock_asp_in),
    .q_sync(asp_level), .rise_pulse(tick_asp)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_got (
    .clock(clock), .reset(reset), .d_in(clock_got_in),
    .q_sync(got_level), .rise_pulse(tick_got)
  );

  // Sensors only need the synchronized level; their edge pulses are not used.
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_soil (
    .clock(clock), .reset(reset), .d_in(soil_dry),
    .q_sync(soil_dry_s), .rise_pulse(sensor_rise[0])
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tank (
    .clock(clock), .reset(reset), .d_in(tank_low),
    .q_sync(tank_low_s), .rise_pulse(sensor_rise[1])
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mode (
    .clock(clock), .reset(reset), .d_in(mode),
    .q_sync(mode_s), .rise_pulse(sensor_rise[2])
  );

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             run_tick;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    run_tick   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_next = '0;
        if (tank_low_s) begin
          state_next = ALARM;
        end else if (soil_dry_s) begin
          state_next = mode_s ? ASP : GOT;
          cnt_next   = mode_s ? ASP_LOAD : GOT_LOAD;
        end
      end
      ASP, GOT: begin
        // Each run listens only to its own rate; the other tick is ignored.
        run_tick = (state == ASP) ? tick_asp : tick_got;
        if (tank_low_s) begin
          state_next = ALARM;
          cnt_next   = '0;
        end else if (!soil_dry_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (run_tick) begin
          if (cnt == CNT_ONE) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt - CNT_ONE;
          end
        end
      end
      ALARM: begin
        cnt_next = '0;
        if (!tank_low_s) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      valve_asp <= 1'b0;
      valve_got <= 1'b0;
      alarm     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      valve_asp <= (state_next == ASP);
      valve_got <= (state_next == GOT);
      alarm     <= (state_next == ALARM);
      busy      <= (state_next == ASP) || (state_next == GOT);
    end
  end

  assign ticks_left = cnt;

endmodule
